// File: rtl/axis_pkt_source.sv
// axis_pkt_source: command-driven AXI4-Stream packet transmitter with an incrementing payload.
// Latency: descriptor accepted on edge N gives beat 0 at N+1; one bubble cycle between packets.
// Backpressure: TREADY low freezes every payload output; cmd_ready is low for the whole packet.
// Optional inter-beat gap compiled in with `define AXIS_PKT_SOURCE_GAP_EN.
module axis_pkt_source #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 1,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [DATA_W-1:0]     cmd_seed,
  input  logic [DATA_W/8-1:0]   cmd_keep,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [DEST_W-1:0]     cmd_dest,
  input  logic [GAP_W-1:0]      cmd_gap,
  output logic [DATA_W-1:0]     TDATA,
  output logic [DATA_W/8-1:0]   TSTRB,
  output logic [DATA_W/8-1:0]   TKEEP,
  output logic                  TLAST,
  output logic [ID_W-1:0]       TID,
  output logic [DEST_W-1:0]     TDEST,
  output logic [USER_W-1:0]     TUSER,
  output logic                  TVALID,
  input  logic                  TREADY,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
`ifdef AXIS_PKT_SOURCE_GAP_EN
    , ST_GAP = 2'd2
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [KEEP_W-1:0]   keep_q, keep_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
  logic                tlast_q, tlast_d;
  logic                tuser_q, tuser_d;
  logic [ID_W-1:0]     tid_q, tid_d;
  logic [DEST_W-1:0]   tdest_q, tdest_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic [15:0]         pkt_count_q, pkt_count_d;
  logic [LEN_W-1:0]    beat_nxt;

`ifdef AXIS_PKT_SOURCE_GAP_EN
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
`else
  // Gap field is accepted on the port but has no effect in this build.
  logic                unused_cmd_gap;
  assign unused_cmd_gap = ^cmd_gap;
`endif

  assign beat_nxt = beat_q + LEN_W'(1);

  // Next-state and next-output logic; every output is computed here one cycle ahead.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    len_d       = len_q;
    keep_d      = keep_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tid_d       = tid_q;
    tdest_d     = tdest_q;
    pkt_count_d = pkt_count_q;
`ifdef AXIS_PKT_SOURCE_GAP_EN
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          // Latch the descriptor and present beat 0 straight away.
          state_d  = ST_SEND;
          beat_d   = '0;
          len_d    = cmd_len;
          keep_d   = cmd_keep;
          tvalid_d = 1'b1;
          tdata_d  = cmd_seed;
          tlast_d  = (cmd_len == '0);
          tkeep_d  = (cmd_len == '0) ? cmd_keep : '1;
          tuser_d  = 1'b1;
          tid_d    = cmd_id;
          tdest_d  = cmd_dest;
`ifdef AXIS_PKT_SOURCE_GAP_EN
          gap_d    = cmd_gap;
`endif
        end
      end

      ST_SEND: begin
        if (TREADY) begin
          if (tlast_q) begin
            state_d     = ST_IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            tuser_d     = 1'b0;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            // Advance the payload; during a gap it waits here until SEND resumes.
            beat_d  = beat_nxt;
            tdata_d = tdata_q + DATA_W'(1);
            tlast_d = (beat_nxt == len_q);
            tkeep_d = (beat_nxt == len_q) ? keep_q : '1;
            tuser_d = 1'b0;
`ifdef AXIS_PKT_SOURCE_GAP_EN
            if (gap_q != '0) begin
              state_d   = ST_GAP;
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q;
            end
`endif
          end
        end
      end

`ifdef AXIS_PKT_SOURCE_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d  = ST_SEND;
          tvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
`endif

      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    // Handshake and status flags follow the state being entered, so they are registered too.
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      len_q       <= '0;
      keep_q      <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      tid_q       <= '0;
      tdest_q     <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      pkt_count_q <= '0;
`ifdef AXIS_PKT_SOURCE_GAP_EN
      gap_q       <= '0;
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      keep_q      <= keep_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      pkt_count_q <= pkt_count_d;
`ifdef AXIS_PKT_SOURCE_GAP_EN
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_count_q;
  assign TVALID    = tvalid_q;
  assign TDATA     = tdata_q;
  assign TKEEP     = tkeep_q;
  assign TSTRB     = tkeep_q;
  assign TLAST     = tlast_q;
  assign TID       = tid_q;
  assign TDEST     = tdest_q;
  assign TUSER     = USER_W'(tuser_q);

endmodule

// File: tb/tb_axis_pkt_source.sv
// tb_axis_pkt_source: table vectors, hand sequences and random traffic against a packet-level model.
// Latency: checks beat 0 one cycle after accept and the one-cycle inter-packet bubble.
// Backpressure: a negedge monitor checks payload hold while stalled and scores every transfer.
module tb_axis_pkt_source;

  localparam int DW = 32, KW = 4, IW = 4, DSW = 4, UW = 1, LW = 8, GW = 4;

  typedef struct {
    logic [LW-1:0]  len;
    logic [DW-1:0]  seed;
    logic [KW-1:0]  keep;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [GW-1:0]  gap;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          exp_beats;
    logic [DW-1:0] exp_last_data;
    logic [KW-1:0] exp_last_keep;
  } vec_t;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [LW-1:0]  cmd_len = '0;
  logic [DW-1:0]  cmd_seed = '0;
  logic [KW-1:0]  cmd_keep = '0;
  logic [IW-1:0]  cmd_id = '0;
  logic [DSW-1:0] cmd_dest = '0;
  logic [GW-1:0]  cmd_gap = '0;
  logic [DW-1:0]  TDATA;
  logic [KW-1:0]  TSTRB, TKEEP;
  logic           TLAST, TVALID;
  logic [IW-1:0]  TID;
  logic [DSW-1:0] TDEST;
  logic [UW-1:0]  TUSER;
  logic           TREADY = 1'b0;
  logic           busy;
  logic [15:0]    pkt_count;

  axis_pkt_source #(.DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW), .LEN_W(LW), .GAP_W(GW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .cmd_keep(cmd_keep), .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_gap(cmd_gap),
    .TDATA(TDATA), .TSTRB(TSTRB), .TKEEP(TKEEP), .TLAST(TLAST), .TID(TID), .TDEST(TDEST),
    .TUSER(TUSER), .TVALID(TVALID), .TREADY(TREADY), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int xfer_n = 0;
  int xfer_gap = 0;
  int last_xfer_cyc = 0;
  int t_last = 0;
  int b2b_gap = 0;
  bit accepted = 0;
  bit stall_q = 0;
  logic [49:0] snap = '0;
  logic [49:0] exp_q[$];
  cmd_t cmd_q[$];
  cmd_t cur;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [49:0] act_word();
    return {TDATA, TKEEP, TSTRB, TLAST, TUSER[0], TID, TDEST};
  endfunction

  // Reference model: a packet expands to len+1 beats computed directly from the descriptor.
  task automatic push_model(input cmd_t c);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    for (int b = 0; b <= int'(c.len); b++) begin
      d = c.seed + DW'(b);
      k = (b == int'(c.len)) ? c.keep : {KW{1'b1}};
      exp_q.push_back({d, k, k, (b == int'(c.len)), (b == 0), c.id, c.dest});
    end
  endtask

  // Monitor: score each transfer, check hold during stalls, record timing.
  always @(negedge ACLK) begin
    logic [49:0] e;
    if (TVALID === 1'b1 && TREADY === 1'b1) begin
      xfer_n++;
      xfer_gap = cyc - last_xfer_cyc;
      last_xfer_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: got beat data %0h, expected no beat", TDATA);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 64'(act_word()), 64'(e));
      end
    end
    if (stall_q) chk("stall_hold", 64'({TVALID, act_word()}), 64'({1'b1, snap}));
    if (TVALID === 1'b1 && TUSER[0] === 1'b1 && !stall_q) b2b_gap = cyc - t_last;
    if (TVALID === 1'b1 && TREADY === 1'b1 && TLAST === 1'b1) t_last = cyc;
    stall_q = (TVALID === 1'b1) && (TREADY === 1'b0);
    snap = act_word();
  end

  // One clock: decide acceptance before the edge, update model and command bus after it.
  task automatic step();
    bit acc;
    @(negedge ACLK);
    acc = (cmd_valid === 1'b1) && (cmd_ready === 1'b1) && (ARESET === 1'b0);
    @(posedge ACLK);
    #1;
    accepted = acc;
    if (acc) begin
      push_model(cur);
      n_acc++;
      cmd_valid = 1'b0;
    end
    if (!cmd_valid && cmd_q.size() != 0) begin
      cur = cmd_q.pop_front();
      cmd_len = cur.len; cmd_seed = cur.seed; cmd_keep = cur.keep;
      cmd_id = cur.id; cmd_dest = cur.dest; cmd_gap = cur.gap;
      cmd_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input string name);
    bit done = 0;
    for (int t = 0; t < 50 && !done; t++) begin
      step();
      done = accepted;
    end
    chk(name, 64'(done), 64'(1));
  endtask

  vec_t tbl[5];

  initial begin
    int nb;
    int pc0;
    int n_rand;
    int gen;
    logic [DW-1:0] last_d;
    logic [KW-1:0] last_k;
    logic [9:0] pat;
    cmd_t c;

    tbl[0] = '{'{8'd3,   32'h0000_0010, 4'h3, 4'h1, 4'h2, 4'h0}, 4,   32'h0000_0013, 4'h3};
    tbl[1] = '{'{8'd0,   32'h0000_0055, 4'h1, 4'h3, 4'h4, 4'h0}, 1,   32'h0000_0055, 4'h1};
    tbl[2] = '{'{8'd2,   32'hFFFF_FFFE, 4'hF, 4'hF, 4'h0, 4'h0}, 3,   32'h0000_0000, 4'hF};
    tbl[3] = '{'{8'd1,   32'hABCD_0000, 4'h0, 4'h7, 4'h9, 4'h0}, 2,   32'hABCD_0001, 4'h0};
    tbl[4] = '{'{8'd255, 32'h0000_0000, 4'h7, 4'h2, 4'hC, 4'h0}, 256, 32'h0000_00FF, 4'h7};

    // Reset state.
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("reset_outputs", 64'({TVALID, TLAST, TDATA, TKEEP, TSTRB, TID, TDEST, TUSER, busy, pkt_count}), 64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    ARESET = 1'b0;
    step();
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    // Table-driven packets with TREADY held high.
    TREADY = 1'b1;
    for (int v = 0; v < 5; v++) begin
      pc0 = int'(pkt_count);
      cmd_q.push_back(tbl[v].c);
      wait_accept("tbl_accept");
      chk("tbl_first_valid", 64'(TVALID), 64'(1));
      nb = 0;
      last_d = '0;
      last_k = '0;
      for (int t = 0; t < 300 && TVALID === 1'b1; t++) begin
        nb++;
        if (TLAST === 1'b1) begin
          last_d = TDATA;
          last_k = TKEEP;
        end
        step();
      end
      chk("tbl_beats", 64'(nb), 64'(tbl[v].exp_beats));
      chk("tbl_last_data", 64'(last_d), 64'(tbl[v].exp_last_data));
      chk("tbl_last_keep", 64'(last_k), 64'(tbl[v].exp_last_keep));
      chk("tbl_pkt_count", 64'(pkt_count), 64'(16'(pc0 + 1)));
      chk("tbl_bubble_ready", 64'({cmd_ready, busy}), 64'(2'b10));
    end

    // Backpressure: three stalled cycles on every beat.
    TREADY = 1'b0;
    nb = xfer_n;
    cmd_q.push_back('{8'd2, 32'h0000_0100, 4'h3, 4'h5, 4'hA, 4'h0});
    wait_accept("bp_accept");
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 3; s++) begin
        chk("bp_valid_held", 64'(TVALID), 64'(1));
        step();
      end
      TREADY = 1'b1;
      step();
      TREADY = 1'b0;
    end
    chk("bp_transfers", 64'(xfer_n - nb), 64'(3));
    chk("bp_done_idle", 64'(TVALID), 64'(0));

    // Back-to-back: second descriptor waits with cmd_valid high.
    TREADY = 1'b1;
    pc0 = int'(pkt_count);
    nb = n_acc;
    cmd_q.push_back('{8'd1, 32'h0000_0300, 4'h1, 4'h1, 4'h1, 4'h0});
    cmd_q.push_back('{8'd1, 32'h0000_0400, 4'h3, 4'h2, 4'h2, 4'h0});
    for (int t = 0; t < 40 && !(n_acc - nb == 2 && exp_q.size() == 0 && TVALID === 1'b0); t++) step();
    chk("b2b_gap", 64'(b2b_gap), 64'(2));
    chk("b2b_pkt_count", 64'(pkt_count), 64'(16'(pc0 + 2)));

    // Inter-beat gap behaviour.
`ifdef AXIS_PKT_SOURCE_GAP_EN
    cmd_q.push_back('{8'd2, 32'h0000_0500, 4'hF, 4'h3, 4'h3, 4'd3});
    wait_accept("gap_accept");
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      pat[i] = TVALID;
      step();
    end
    chk("gap_valid_pattern", 64'(pat), 64'(10'b0100010001));
    chk("gap_xfer_spacing", 64'(xfer_gap), 64'(4));
`else
    cmd_q.push_back('{8'd2, 32'h0000_0500, 4'hF, 4'h3, 4'h3, 4'd7});
    wait_accept("gap_accept");
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      pat[i] = TVALID;
      step();
    end
    chk("gap_ignored_pattern", 64'(pat[3:0]), 64'(4'b0111));
    chk("gap_ignored_spacing", 64'(xfer_gap), 64'(1));
`endif

    // Reset in the middle of a packet.
    cmd_q.push_back('{8'd7, 32'h0000_0200, 4'hF, 4'h4, 4'h4, 4'h0});
    wait_accept("rst_accept");
    step();
    step();
    chk("rst_on_beat2", 64'({TVALID, TDATA}), 64'({1'b1, 32'h0000_0202}));
    ARESET = 1'b1;
    step();
    chk("rst_outputs", 64'({TVALID, busy, cmd_ready, pkt_count}), 64'(0));
    ARESET = 1'b0;
    exp_q.delete();
    step();
    chk("rst_release_ready", 64'({cmd_ready, TVALID}), 64'(2'b10));

    // Random descriptors with random TREADY against the model.
    n_rand = 40;
    gen = 0;
    pc0 = int'(pkt_count);
    nb = n_acc;
    for (int t = 0; t < 20000 && !(n_acc - nb == n_rand && exp_q.size() == 0); t++) begin
      if (cmd_q.size() == 0 && gen < n_rand && $urandom_range(0, 2) == 0) begin
        c.len  = LW'($urandom_range(0, 20));
        c.seed = $urandom;
        c.keep = KW'($urandom);
        c.id   = IW'($urandom);
        c.dest = DSW'($urandom);
        c.gap  = GW'($urandom_range(0, 3));
        cmd_q.push_back(c);
        gen++;
      end
      TREADY = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand_accepted", 64'(n_acc - nb), 64'(n_rand));
    chk("rand_drained", 64'(exp_q.size()), 64'(0));
    chk("rand_pkt_count", 64'(pkt_count), 64'(16'(pc0 + n_rand)));
    TREADY = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
